// File: rtl/pu_riscv_dext_q.sv
// Queued data external access: request FIFO toward the AHB-Lite BIU plus an in-order
// tracking FIFO of outstanding transactions. Optional macro: PU_RISCV_DEXT_ERR_CAPTURE_EN.
module pu_riscv_dext_q #(
  parameter int XLEN    = 64,
  parameter int PLEN    = 64,
  parameter int QDEPTH  = 4,
  parameter int MAXINFL = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            mem_req_i,
  input  logic [XLEN-1:0] mem_adr_i,
  input  logic [2:0]      mem_size_i,
  input  logic [2:0]      mem_type_i,
  input  logic            mem_lock_i,
  input  logic [2:0]      mem_prot_i,
  input  logic            mem_we_i,
  input  logic [XLEN-1:0] mem_d_i,
  output logic            mem_rdy_o,
  output logic            mem_adr_ack_o,
  output logic [PLEN-1:0] mem_adr_o,
  output logic [XLEN-1:0] mem_q_o,
  output logic            mem_ack_o,
  output logic            mem_err_o,
  output logic            busy_o,
  output logic            biu_stb_o,
  input  logic            biu_stb_ack_i,
  output logic [PLEN-1:0] biu_adri_o,
  input  logic [PLEN-1:0] biu_adro_i,
  output logic [2:0]      biu_size_o,
  output logic [2:0]      biu_type_o,
  output logic [2:0]      biu_prot_o,
  output logic            biu_lock_o,
  output logic            biu_we_o,
  output logic [XLEN-1:0] biu_d_o,
  input  logic [XLEN-1:0] biu_q_i,
  input  logic            biu_ack_i,
  input  logic            biu_err_i,
  input  logic            err_clr_i,
  output logic            err_vld_o,
  output logic [PLEN-1:0] err_adr_o
);

  localparam int QAW = $clog2(QDEPTH);
  localparam int QCW = QAW + 1;
  localparam int TAW = (MAXINFL > 1) ? $clog2(MAXINFL) : 1;
  localparam int TCW = $clog2(MAXINFL) + 1;

  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic [2:0]      size;
    logic [2:0]      typ;
    logic            lock;
    logic [2:0]      prot;
    logic            we;
    logic [XLEN-1:0] d;
  } req_t;

  // Handshakes: a CPU request transfers when mem_req_i && mem_rdy_o; a BIU strobe
  // transfers when biu_stb_o && biu_stb_ack_i. Neither valid depends on its ready.
  req_t            q_mem [QDEPTH];
  logic [QAW-1:0]  q_wr, q_rd;
  logic [QCW-1:0]  q_cnt;
  logic            q_full, q_empty, enq, deq, lock_ok;
  req_t            head;
  logic [PLEN+XLEN-1:0] head_adr_ext;

  logic [TAW-1:0]     t_wr, t_rd;
  logic [TCW-1:0]     infl_cnt;
  logic [MAXINFL-1:0] t_dis;
  logic               resp, pop, pop_dis;

  function automatic logic [TAW-1:0] t_nxt(input logic [TAW-1:0] p);
    return (p == TAW'(MAXINFL - 1)) ? '0 : p + TAW'(1);
  endfunction

  assign q_full        = (q_cnt == QCW'(QDEPTH));
  assign q_empty       = (q_cnt == '0);
  assign head          = q_mem[q_rd];
  assign mem_rdy_o     = !q_full && !clr_i;
  assign enq           = mem_req_i && mem_rdy_o;
  assign mem_adr_ack_o = enq;

  // A locked access waits until every earlier transaction has completed.
  assign lock_ok   = !head.lock || (infl_cnt == '0);
  assign biu_stb_o = !q_empty && (infl_cnt < TCW'(MAXINFL)) && !clr_i && lock_ok;
  assign deq       = biu_stb_o && biu_stb_ack_i;

  assign head_adr_ext = {{PLEN{1'b0}}, head.adr};
  assign biu_adri_o   = head_adr_ext[PLEN-1:0];
  assign biu_size_o   = head.size;
  assign biu_type_o   = head.typ;
  assign biu_prot_o   = head.prot;
  assign biu_lock_o   = head.lock;
  assign biu_we_o     = head.we;
  assign biu_d_o      = head.d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
    end else begin
      if (enq) q_wr <= q_wr + QAW'(1);
      if (deq) q_rd <= q_rd + QAW'(1);
      if (enq && !deq)      q_cnt <= q_cnt + QCW'(1);
      else if (!enq && deq) q_cnt <= q_cnt - QCW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) q_mem[q_wr] <= {mem_adr_i, mem_size_i, mem_type_i, mem_lock_i,
                             mem_prot_i, mem_we_i, mem_d_i};
  end

  assign resp    = biu_ack_i || biu_err_i;
  assign pop     = resp && (infl_cnt != '0);
  assign pop_dis = t_dis[t_rd];

  // A flush cannot coincide with a push because the strobe is gated by clr_i.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      t_wr     <= '0;
      t_rd     <= '0;
      infl_cnt <= '0;
      t_dis    <= '0;
    end else begin
      if (deq) t_wr <= t_nxt(t_wr);
      if (pop) t_rd <= t_nxt(t_rd);
      if (deq && !pop)      infl_cnt <= infl_cnt + TCW'(1);
      else if (!deq && pop) infl_cnt <= infl_cnt - TCW'(1);
      if (clr_i)    t_dis       <= '1;
      else if (deq) t_dis[t_wr] <= 1'b0;
    end
  end

  assign mem_ack_o = pop && !pop_dis && !clr_i && biu_ack_i && !biu_err_i;
  assign mem_err_o = pop && !pop_dis && !clr_i && biu_err_i;
  assign mem_adr_o = biu_adro_i;
  assign mem_q_o   = biu_q_i;
  assign busy_o    = !q_empty || (infl_cnt != '0);

`ifdef PU_RISCV_DEXT_ERR_CAPTURE_EN
  logic [PLEN-1:0] t_adr [MAXINFL];

  always_ff @(posedge clk_i) begin
    if (deq) t_adr[t_wr] <= biu_adri_o;
  end

  // The first reported error sticks until cleared; a new capture beats a clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_vld_o <= 1'b0;
      err_adr_o <= '0;
    end else if (mem_err_o && !err_vld_o) begin
      err_vld_o <= 1'b1;
      err_adr_o <= t_adr[t_rd];
    end else if (err_clr_i) begin
      err_vld_o <= 1'b0;
      err_adr_o <= '0;
    end
  end
`else
  assign err_vld_o = 1'b0;
  assign err_adr_o = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{err_clr_i, head_adr_ext[PLEN+XLEN-1:PLEN]};

endmodule

// File: tb/tb_pu_riscv_dext_q.sv
// Bench for pu_riscv_dext_q: directed scenarios then random traffic, every cycle
// compared against a queue-based reference model of the request and tracking FIFOs.
module tb_pu_riscv_dext_q;
  localparam int XLEN = 64, PLEN = 64, QDEPTH = 4, MAXINFL = 4;

  logic            clk_i = 1'b0, rst_ni = 1'b0, clr_i = 1'b0;
  logic            mem_req_i = 1'b0, mem_lock_i = 1'b0, mem_we_i = 1'b0;
  logic [XLEN-1:0] mem_adr_i = '0, mem_d_i = '0;
  logic [2:0]      mem_size_i = '0, mem_type_i = '0, mem_prot_i = '0;
  logic            mem_rdy_o, mem_adr_ack_o, mem_ack_o, mem_err_o, busy_o;
  logic [PLEN-1:0] mem_adr_o;
  logic [XLEN-1:0] mem_q_o;
  logic            biu_stb_o, biu_stb_ack_i = 1'b0;
  logic [PLEN-1:0] biu_adri_o, biu_adro_i = '0;
  logic [2:0]      biu_size_o, biu_type_o, biu_prot_o;
  logic            biu_lock_o, biu_we_o;
  logic [XLEN-1:0] biu_d_o, biu_q_i = '0;
  logic            biu_ack_i = 1'b0, biu_err_i = 1'b0, err_clr_i = 1'b0, err_vld_o;
  logic [PLEN-1:0] err_adr_o;

  pu_riscv_dext_q #(.XLEN(XLEN), .PLEN(PLEN), .QDEPTH(QDEPTH), .MAXINFL(MAXINFL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
    .mem_req_i(mem_req_i), .mem_adr_i(mem_adr_i), .mem_size_i(mem_size_i),
    .mem_type_i(mem_type_i), .mem_lock_i(mem_lock_i), .mem_prot_i(mem_prot_i),
    .mem_we_i(mem_we_i), .mem_d_i(mem_d_i), .mem_rdy_o(mem_rdy_o),
    .mem_adr_ack_o(mem_adr_ack_o), .mem_adr_o(mem_adr_o), .mem_q_o(mem_q_o),
    .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o), .busy_o(busy_o),
    .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_adri_o(biu_adri_o),
    .biu_adro_i(biu_adro_i), .biu_size_o(biu_size_o), .biu_type_o(biu_type_o),
    .biu_prot_o(biu_prot_o), .biu_lock_o(biu_lock_o), .biu_we_o(biu_we_o),
    .biu_d_o(biu_d_o), .biu_q_i(biu_q_i), .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i),
    .err_clr_i(err_clr_i), .err_vld_o(err_vld_o), .err_adr_o(err_adr_o)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  // Reference model: pending requests and outstanding transactions as queues
  typedef struct packed {
    logic [63:0] adr;
    logic [2:0]  size, typ, prot;
    logic        lock, we;
    logic [63:0] d;
  } mreq_t;
  typedef struct packed {
    logic        dis;
    logic [63:0] adr;
  } trk_t;

  mreq_t       req_q[$];
  trk_t        trk_q[$];
  logic        m_err_vld = 1'b0;
  logic [63:0] m_err_adr = '0;
  int          n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle: apply inputs at negedge, compare outputs against the model, advance model
  task automatic drive(input bit r, input logic [63:0] a, input bit lk, input bit c,
                       input bit sa, input bit ak, input bit er, input bit ec);
    bit    e_rdy, e_aack, e_stb, pop, dis, e_ack, e_err;
    mreq_t hd, cur;
    trk_t  popped;
    @(negedge clk_i);
    mem_req_i = r; mem_adr_i = a; mem_lock_i = lk; clr_i = c;
    mem_we_i = 1'($urandom_range(0, 1)); mem_d_i = {$urandom, $urandom};
    mem_size_i = 3'($urandom_range(0, 7)); mem_type_i = 3'($urandom_range(0, 7));
    mem_prot_i = 3'($urandom_range(0, 7));
    biu_stb_ack_i = sa; biu_ack_i = ak; biu_err_i = er; err_clr_i = ec;
    biu_q_i = {$urandom, $urandom}; biu_adro_i = {$urandom, $urandom};
    #1;
    hd = (req_q.size() > 0) ? req_q[0] : '0;
    cur = '{adr: a, size: mem_size_i, typ: mem_type_i, prot: mem_prot_i,
            lock: lk, we: mem_we_i, d: mem_d_i};
    e_rdy  = (req_q.size() < QDEPTH) && !c;
    e_aack = r && e_rdy;
    e_stb  = (req_q.size() > 0) && (trk_q.size() < MAXINFL) && !c &&
             (!hd.lock || trk_q.size() == 0);
    pop    = (ak || er) && (trk_q.size() > 0);
    dis    = pop ? trk_q[0].dis : 1'b0;
    e_ack  = pop && !dis && !c && ak && !er;
    e_err  = pop && !dis && !c && er;

    check("mem_rdy", 64'(mem_rdy_o), 64'(e_rdy));
    check("adr_ack", 64'(mem_adr_ack_o), 64'(e_aack));
    check("biu_stb", 64'(biu_stb_o), 64'(e_stb));
    check("mem_ack", 64'(mem_ack_o), 64'(e_ack));
    check("mem_err", 64'(mem_err_o), 64'(e_err));
    check("busy", 64'(busy_o), 64'((req_q.size() > 0) || (trk_q.size() > 0)));
    check("err_vld", 64'(err_vld_o), 64'(m_err_vld));
    check("err_adr", err_adr_o, m_err_adr);
    check("mem_adr", mem_adr_o, biu_adro_i);
    if (e_ack) check("mem_q", mem_q_o, biu_q_i);
    if (e_stb) begin
      check("biu_adri", biu_adri_o, hd.adr);
      check("biu_fields", 64'({biu_size_o, biu_type_o, biu_prot_o, biu_lock_o, biu_we_o}),
            64'({hd.size, hd.typ, hd.prot, hd.lock, hd.we}));
      check("biu_d", biu_d_o, hd.d);
    end

    popped = '0;
    if (pop) popped = trk_q.pop_front();
    if (c) begin
      foreach (trk_q[i]) trk_q[i].dis = 1'b1;
      req_q.delete();
    end else begin
      if (e_stb && sa) begin
        hd = req_q.pop_front();
        trk_q.push_back('{dis: 1'b0, adr: hd.adr});
      end
      if (e_aack) req_q.push_back(cur);
    end
`ifdef PU_RISCV_DEXT_ERR_CAPTURE_EN
    if (e_err && !m_err_vld) begin
      m_err_vld = 1'b1;
      m_err_adr = popped.adr;
    end else if (ec) begin
      m_err_vld = 1'b0;
      m_err_adr = '0;
    end
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; mem_req_i = 1'b0; clr_i = 1'b0; biu_stb_ack_i = 1'b0;
    biu_ack_i = 1'b0; biu_err_i = 1'b0; err_clr_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("rst_rdy", 64'(mem_rdy_o), 64'd1);
    check("rst_stb", 64'(biu_stb_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ack", 64'({mem_ack_o, mem_err_o, mem_adr_ack_o}), 64'd0);
    check("rst_err_vld", 64'(err_vld_o), 64'd0);
    check("rst_err_adr", err_adr_o, 64'd0);
    req_q.delete();
    trk_q.delete();
    m_err_vld = 1'b0;
    m_err_adr = '0;
    rst_ni = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single read
    drive(1, 64'h1000, 0, 0, 0, 0, 0, 0);
    drive(0, '0, 0, 0, 1, 0, 0, 0);
    idle(1);
    drive(0, '0, 0, 0, 0, 1, 0, 0);
    idle(2);

    // Backpressure: fill the queue, then the 5th request waits past the first stb_ack
    for (int i = 0; i < 5; i++) drive(1, {$urandom, $urandom}, 0, 0, 0, 0, 0, 0);
    drive(1, 64'h5555, 0, 0, 1, 0, 0, 0);
    drive(1, 64'h5555, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) drive(0, '0, 0, 0, 1, 1, 0, 0);

    // Outstanding limit
    for (int i = 0; i < 6; i++) drive(1, {$urandom, $urandom}, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, '0, 0, 0, 1, 0, 0, 0);
    drive(0, '0, 0, 0, 1, 1, 0, 0);
    drive(0, '0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, '0, 0, 0, 1, 1, 0, 0);

    // Flush with 3 in flight and 2 queued
    for (int i = 0; i < 5; i++) drive(1, {$urandom, $urandom}, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, '0, 0, 0, 1, 0, 0, 0);
    drive(1, 64'h7000, 0, 0, 0, 0, 0, 0);
    drive(1, 64'h7100, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, '0, 0, 0, 0, 1, 0, 0);
    drive(1, 64'h8000, 0, 0, 0, 0, 0, 0);
    drive(0, '0, 0, 0, 1, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 1, 0, 0);

    // Locked access behind two outstanding transactions, then a stray ack
    drive(1, 64'h9000, 0, 0, 0, 0, 0, 0);
    drive(1, 64'h9100, 0, 0, 1, 0, 0, 0);
    drive(1, 64'h9200, 1, 0, 1, 0, 0, 0);
    drive(0, '0, 0, 0, 1, 0, 0, 0);
    drive(0, '0, 0, 0, 1, 1, 0, 0);
    drive(0, '0, 0, 0, 1, 1, 0, 0);
    drive(0, '0, 0, 0, 1, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 1, 0, 0);
    drive(0, '0, 0, 0, 0, 1, 0, 0);

    // Two errors, then clear the captured one
    drive(1, 64'h2000, 0, 0, 0, 0, 0, 0);
    drive(1, 64'h3000, 0, 0, 1, 0, 0, 0);
    drive(0, '0, 0, 0, 1, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 0, 1, 0);
    drive(0, '0, 0, 0, 0, 0, 1, 0);
    idle(1);
    drive(0, '0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit ak, er;
      ak = 1'b0;
      er = 1'b0;
      if (trk_q.size() > 0) begin
        ak = ($urandom_range(0, 2) == 0);
        er = ($urandom_range(0, 11) == 0);
      end else begin
        ak = ($urandom_range(0, 29) == 0);
      end
      drive($urandom_range(0, 2) != 0, {$urandom, $urandom}, $urandom_range(0, 7) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, ak, er,
            $urandom_range(0, 19) == 0);
    end

    // Reset with traffic outstanding; late responses must be ignored
    for (int i = 0; i < 4; i++) drive(1, {$urandom, $urandom}, 0, 0, 1, 0, 0, 0);
    do_reset();
    drive(0, '0, 0, 0, 0, 1, 0, 0);
    drive(0, '0, 0, 0, 0, 0, 1, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
